jtag_debug_cmd_queue: RTL
=========================

Name: jtag_debug_cmd_queue

Overview:
- Next-generation system-clock half of the CPU debug slave.
- Synchronises the virtual-JTAG update-IR/update-DR events into the CPU clock domain and captures IR and shift-register snapshots.
- Queues commands in a parametrised FIFO instead of a single-shot latch, so back-to-back host scans are not lost while the debug core is busy.
- On dequeue, decodes each command into one-hot take_action / take_no_action strobes for a parametrised number of command classes and breakpoint channels.

Parameters:
- SR_WIDTH, 38, width of the JTAG data shift register snapshot.
- IR_WIDTH, 2, width of the virtual IR; command classes = 2**IR_WIDTH.
- NUM_BRK, 4, breakpoint channels (power of 2, >=2); BRK_SEL_W = clog2(NUM_BRK).
- SYNC_STAGES, 2, synchroniser depth for vs_udr/vs_uir (>=2).
- FIFO_DEPTH, 4, command queue entries (power of 2, >=2).

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- vs_udr  in  1  update-DR level from JTAG side; asynchronous to clk.
- vs_uir  in  1  update-IR level from JTAG side; asynchronous to clk.
- ir_in  in  IR_WIDTH  virtual IR; quasi-static around a vs_uir rise.
- sr  in  SR_WIDTH  shift register; quasi-static around a vs_udr rise.
- cmd_ready  in  1  consumer accepts the head command.
- clr_overflow  in  1  clears the sticky overflow flag.
- cmd_valid  out  1  FIFO non-empty.
- jdo  out  SR_WIDTH  sr snapshot of the head entry.
- cmd_ir  out  IR_WIDTH  IR of the head entry.
- cmd_count  out  clog2(FIFO_DEPTH)+1  occupancy.
- take_action  out  2**IR_WIDTH  one-hot pulse on dequeue.
- take_no_action  out  2**IR_WIDTH  one-hot pulse on dequeue.
- brk_sel  out  NUM_BRK  one-hot breakpoint channel, valid with a take_action pulse of class BRK_CLASS.
- overflow  out  1  sticky; set when a command is dropped.

Behaviour:
- Reset: all outputs 0, FIFO empty, ir_reg=0, synchroniser flops 0, arming counter 0.
- Synchronisers:
  - vs_udr and vs_uir each pass through SYNC_STAGES flops, then a previous-value flop.
  - Event = synced & ~prev.
- Arming:
  - After reset deasserts, a counter runs SYNC_STAGES+1 cycles.
  - Events are masked until it saturates, so a level held high through reset produces no event.
- Capture latency:
  - uir event: ir_reg <= ir_in.
  - udr event: push {ir_reg, sr}.
  - Push occurs SYNC_STAGES+1 cycles after the first clk edge that samples vs_udr high.
  - cmd_valid rises on the following cycle.
- Simultaneous uir and udr events in one cycle: the push uses the old ir_reg; ir_reg updates in the same cycle.
- Dequeue: pop = cmd_valid & cmd_ready.
- Decode, registered, 1-cycle pulses in the cycle after the pop:
  - act bit = sr[SR_WIDTH-1].
  - take_action[ir] = pop & act.
  - take_no_action[ir] = pop & ~act.
  - BRK_CLASS = 2**IR_WIDTH-2.
  - When ir == BRK_CLASS, brk_sel = onehot(sr[SR_WIDTH-2 -: BRK_SEL_W]); otherwise 0.
- Head outputs: jdo/cmd_ir are stable while cmd_valid=1 and cmd_ready=0; a value is undefined-but-held (last entry) when empty.
- Full:
  - Push while full and no pop in the same cycle → entry dropped, overflow <= 1.
  - Push and pop in the same cycle while full → both succeed; count unchanged.
- Empty: a push in the same cycle as cmd_ready=1 does not pop; the new entry is visible next cycle.
- Overflow flag:
  - clr_overflow clears it.
  - A drop in the same cycle as clr_overflow leaves overflow=1 (set wins).
- Pointers wrap modulo FIFO_DEPTH; count is 0..FIFO_DEPTH.
- Reset mid-operation: queue flushed, pending pulses cancelled, re-arming required.

Decomposition:
- Package jtag_debug_pkg:
  - BRK_CLASS function.
  - clog2-derived widths.
  - Command struct typedef {ir, sr}.
  - Class index constants OCIMEM=0, TRACECTRL=1, BREAK=2.
- Sub-module jtag_debug_cmd_fifo: synchronous FIFO with push/pop/full/empty/count and the full-plus-pop-push rule.
- Synchronisers and decode stay in the top level.

Test Plan:
- Defaults; vs_uir rise with ir_in=2, then vs_udr rise with sr[37]=1, sr[36:35]=2'b10 → push 3 cycles after sampling; cmd_valid the next cycle; with cmd_ready=1: take_action=4'b0100, brk_sel=4'b0100 for 1 cycle.
- ir=0, sr[37]=0, sr=38'h0_1234_5678 → jdo=38'h0_1234_5678; take_no_action=4'b0001; brk_sel=0.
- cmd_ready=0; 5 udr events → cmd_count=4; overflow=1; the 5th dropped; draining yields the first 4 sr values in order.
- FIFO full; udr event coincides with pop → cmd_count stays 4; overflow stays 0.
- vs_udr held high across reset release → no push; cmd_count=0 after 10 cycles.
- Simultaneous uir event (ir 1→3) and udr event → queued cmd_ir=1; next udr gives cmd_ir=3.

Source files
------------

// File: rtl/jtag_debug_pkg.sv
// jtag_debug_pkg: shared widths, command record and class helpers for the debug command queue
package jtag_debug_pkg;
  localparam int CMD_SR_W = 38;
  localparam int CMD_IR_W = 2;
  localparam int CMD_BRK_SEL_W = $clog2(4);
  localparam int CMD_COUNT_W = $clog2(4) + 1;
  localparam int CLS_OCIMEM = 0;
  localparam int CLS_TRACECTRL = 1;
  localparam int CLS_BREAK = 2;
  typedef struct packed {
    logic [CMD_IR_W-1:0] ir;
    logic [CMD_SR_W-1:0] sr;
  } cmd_t;
  function automatic int brk_class(input int ir_w);
    return (1 << ir_w) - 2;
  endfunction
endpackage

// File: rtl/jtag_debug_cmd_fifo.sv
// jtag_debug_cmd_fifo: synchronous command FIFO; a push into a full queue succeeds only alongside a pop
module jtag_debug_cmd_fifo #(
  parameter int W = 40,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [W-1:0]               i_data,
  output logic [W-1:0]               o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd, w_head;
  logic [AW:0] r_count;
  logic w_do_pop, w_do_push;
  assign o_full = r_count == (AW+1)'(DEPTH);
  assign o_empty = r_count == '0;
  assign o_count = r_count;
  assign w_do_pop = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  // when empty, keep presenting the most recently consumed entry
  assign w_head = o_empty ? r_rd - 1'b1 : r_rd;
  assign o_data = r_mem[w_head];
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_mem[r_wr] <= i_data;
      r_wr <= r_wr + AW'(w_do_push);
      r_rd <= r_rd + AW'(w_do_pop);
      r_count <= r_count + {{AW{1'b0}}, w_do_push} - {{AW{1'b0}}, w_do_pop};
    end
  end
endmodule

// File: rtl/jtag_debug_cmd_queue.sv
// jtag_debug_cmd_queue: syncs JTAG update events into clk, queues {ir, sr} commands and
// decodes each dequeued command into one-hot action / no-action / breakpoint pulses
module jtag_debug_cmd_queue
  import jtag_debug_pkg::*;
#(
  parameter int SR_WIDTH = 38,
  parameter int IR_WIDTH = 2,
  parameter int NUM_BRK = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          vs_udr,
  input  logic                          vs_uir,
  input  logic [IR_WIDTH-1:0]           ir_in,
  input  logic [SR_WIDTH-1:0]           sr,
  input  logic                          cmd_ready,
  input  logic                          clr_overflow,
  output logic                          cmd_valid,
  output logic [SR_WIDTH-1:0]           jdo,
  output logic [IR_WIDTH-1:0]           cmd_ir,
  output logic [$clog2(FIFO_DEPTH):0]   cmd_count,
  output logic [2**IR_WIDTH-1:0]        take_action,
  output logic [2**IR_WIDTH-1:0]        take_no_action,
  output logic [NUM_BRK-1:0]            brk_sel,
  output logic                          overflow
);
  localparam int NCLS = 2**IR_WIDTH;
  localparam int BRK_SEL_W = $clog2(NUM_BRK);
  localparam int ARM_W = $clog2(SYNC_STAGES + 2);
  localparam logic [IR_WIDTH-1:0] BRK_IR = IR_WIDTH'(brk_class(IR_WIDTH));
  logic [SYNC_STAGES-1:0] r_udr_sync, r_uir_sync;
  logic r_udr_prev, r_uir_prev, r_udr_evt, r_uir_evt, r_ovf;
  logic [ARM_W-1:0] r_arm;
  logic [IR_WIDTH-1:0] r_ir, w_ir;
  logic [SR_WIDTH-1:0] w_sr;
  logic [NCLS-1:0] r_act, r_nact, w_cls;
  logic [NUM_BRK-1:0] r_brk, w_brk;
  logic w_armed, w_udr_s, w_uir_s, w_pop, w_full, w_empty, w_drop;
  assign w_armed = r_arm == ARM_W'(SYNC_STAGES + 1);
  assign w_udr_s = r_udr_sync[SYNC_STAGES-1];
  assign w_uir_s = r_uir_sync[SYNC_STAGES-1];
  assign w_pop = cmd_valid & cmd_ready;
  assign w_drop = r_udr_evt & w_full & ~w_pop;
  assign w_cls = NCLS'(1) << w_ir;
  assign w_brk = NUM_BRK'(1) << w_sr[SR_WIDTH-2 -: BRK_SEL_W];
  jtag_debug_cmd_fifo #(.W(IR_WIDTH + SR_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .i_push(r_udr_evt), .i_pop(w_pop), .i_data({r_ir, sr}),
    .o_data({w_ir, w_sr}), .o_full(w_full), .o_empty(w_empty), .o_count(cmd_count)
  );
  assign cmd_valid = ~w_empty;
  assign jdo = w_sr;
  assign cmd_ir = w_ir;
  assign take_action = r_act;
  assign take_no_action = r_nact;
  assign brk_sel = r_brk;
  assign overflow = r_ovf;
  // events are registered so a push lands SYNC_STAGES+1 edges after vs_udr is first sampled high
  always_ff @(posedge clk) begin
    if (reset) begin
      r_udr_sync <= '0;
      r_uir_sync <= '0;
      r_udr_prev <= 1'b0;
      r_uir_prev <= 1'b0;
      r_udr_evt <= 1'b0;
      r_uir_evt <= 1'b0;
      r_arm <= '0;
      r_ir <= '0;
      r_ovf <= 1'b0;
      r_act <= '0;
      r_nact <= '0;
      r_brk <= '0;
    end else begin
      r_udr_sync <= {r_udr_sync[SYNC_STAGES-2:0], vs_udr};
      r_uir_sync <= {r_uir_sync[SYNC_STAGES-2:0], vs_uir};
      r_udr_prev <= w_udr_s;
      r_uir_prev <= w_uir_s;
      r_udr_evt <= w_armed & w_udr_s & ~r_udr_prev;
      r_uir_evt <= w_armed & w_uir_s & ~r_uir_prev;
      r_arm <= r_arm + ARM_W'(!w_armed);
      r_ir <= r_uir_evt ? ir_in : r_ir;
      r_ovf <= w_drop | (r_ovf & ~clr_overflow);
      r_act <= (w_pop & w_sr[SR_WIDTH-1]) ? w_cls : '0;
      r_nact <= (w_pop & ~w_sr[SR_WIDTH-1]) ? w_cls : '0;
      r_brk <= (w_pop && w_ir == BRK_IR) ? w_brk : '0;
    end
  end
endmodule
